ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Pipelined RV32I(+M) control unit for the 5-stage core. Decodes op/funct3/funct7 in D.
//  Carries the control bundle through the E/M/W pipeline registers, with flush support.
//  Adds M-extension decode and a multi-cycle divide sequencer that stalls the front end.
//  Sits between the instruction register and the datapath; the hazard unit drives flush_e.
// PARAMETERS
//  ENABLE_M    1   1: decode MUL/DIV (funct7=0000001); 0: such encodings are illegal
//  DIV_CYCLES  34  cycles a DIV/DIVU/REM/REMU occupies E (>=1)
//  CNT_W       6   width of divide counter; must satisfy 2**CNT_W > DIV_CYCLES
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  synchronous, active-high
//  op           in   7  instr[6:0], D stage
//  funct3       in   3  instr[14:12], D stage
//  funct7       in   7  instr[31:25], D stage
//  flush_e      in   1  load bubble into E (branch taken / load-use)
//  immsrc_d     out  3  comb: 000 I, 001 S, 010 B, 011 J, 100 U
//  illegal_d    out  1  comb: unsupported encoding in D
//  regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e   out 1 each  E-stage controls
//  resultsrc_e  out  2  00 ALU, 01 mem, 10 PC+4
//  alucontrol_e out  4  0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra,A passB
//  muldiv_e     out  1  E holds an M-ext op; muldiv_op_e out 3 = its funct3
//  regwrite_m, memwrite_m  out 1;  resultsrc_m out 2   M-stage controls
//  regwrite_w   out  1;  resultsrc_w out 2             W-stage controls
//  div_busy     out  1  comb: stall F, D, E this cycle
//  div_done     out  1  comb: last cycle of a divide in E
// BEHAVIOUR
//  Decode: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111,
//   jalr 1100111, lui 0110111 (alu passB), auipc 0010111 (add, PC operand).
//   SUB/SRA iff funct7[5] & op[5] (SRAI via funct7[5]).
//  Illegal:
//   - Unknown op, or R-type funct7 not in {0000000, 0100000, 0000001 (ENABLE_M)}.
//   - Illegal ops enter E as a bubble (all write/jump/branch enables 0); illegal_d=1.
//  Bubble = all E/M/W registers zero. Reset: every registered output 0, FSM IDLE, count 0.
//  Latency: D decode -> E next edge -> M -> W, one cycle per stage.
//  Priority per edge: reset > div hold > flush_e > advance.
//  Divide FSM (div_e = muldiv_e & muldiv_op_e[2]):
//   IDLE: div_e & DIV_CYCLES>1 -> RUN, count=1; div_busy=1 combinationally in this cycle.
//   RUN:  count++ each cycle; div_busy=1 while count<DIV_CYCLES-1; at count==DIV_CYCLES-1 -> LAST.
//   LAST: div_busy=0, div_done=1, E advances, count=0 -> IDLE (RUN again if next E op divides).
//   DIV_CYCLES==1: never busy; div_done pulses in the single E cycle.
//   MUL* ops never busy.
//  While div_busy:
//   - E holds its contents; M loads a bubble; W advances normally.
//   - flush_e is ignored.
//  Back-to-back divides: the second starts its own full DIV_CYCLES window.
//  Reset mid-divide: FSM IDLE, count 0, E bubble at the next edge; no div_done.
// TESTING
//  1. add (R,f7=0) then sub (f7=0100000) -> alucontrol_e 0 then 1; regwrite_w=1 at D+3.
//  2. lw then sw -> resultsrc_e=01, regwrite_e=1; next cycle memwrite_e=1; immsrc_d 000 then 001.
//  3. beq with flush_e=1 on next edge -> E all zero; no regwrite/memwrite reaches M or W.
//  4. div, DIV_CYCLES=34 -> div_busy high 33 cycles, div_done 1 cycle.
//     E constant throughout; regwrite_m=0 during the stall.
//  5. ENABLE_M=0, funct7=0000001 R-type -> illegal_d=1, E bubble; op 1111111 -> illegal_d=1.
//  6. reset asserted at divide cycle 10 -> div_busy=0 next cycle, outputs 0, FSM IDLE.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Pipelined RV32I(+M) control unit.
// The D-stage decoder is combinational. Registered control bundles run D -> E -> M -> W.
// A divide sequencer holds a divide in E for DIV_CYCLES cycles and stalls the front end meanwhile.
// Handshake: none. Stalls are signalled by div_busy. While it is high, E holds its bundle,
// M takes a bubble and W keeps advancing.
module ctrl_pipe #(
    parameter int ENABLE_M   = 1,
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       flush_e,
    output logic [2:0] immsrc_d,
    output logic       illegal_d,
    output logic       regwrite_e,
    output logic       memwrite_e,
    output logic       jump_e,
    output logic       branch_e,
    output logic       alusrc_e,
    output logic [1:0] resultsrc_e,
    output logic [3:0] alucontrol_e,
    output logic       muldiv_e,
    output logic [2:0] muldiv_op_e,
    output logic       regwrite_m,
    output logic       memwrite_m,
    output logic [1:0] resultsrc_m,
    output logic       regwrite_w,
    output logic [1:0] resultsrc_w,
    output logic       div_busy,
    output logic       div_done,
    output logic [1:0] div_state
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_PASSB = 4'hA;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic [1:0] resultsrc;
        logic [3:0] alucontrol;
        logic       muldiv;
        logic [2:0] muldiv_op;
    } ectrl_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } div_state_t;

    ectrl_t      dec;
    ectrl_t      dec_e;
    ectrl_t      e_q;
    logic [3:0]  alu_f3;
    div_state_t  state_q, state_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic        div_e;

    // ALU operation selected by funct3 for R-type and I-ALU instructions.
    // Subtract needs op[5] so that ADDI is never treated as SUB. SRAI is told apart by funct7[5].
    always_comb begin
        alu_f3 = ALU_ADD;
        case (funct3)
            3'b000:  alu_f3 = (funct7[5] & op[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    // Main decoder: builds the control bundle, the immediate format and the illegal flag.
    always_comb begin
        dec       = '0;
        immsrc_d  = 3'b000;
        illegal_d = 1'b0;
        case (op)
            OP_R: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    dec.regwrite   = 1'b1;
                    dec.alucontrol = alu_f3;
                end else if (ENABLE_M != 0 && funct7 == F7_M) begin
                    dec.regwrite  = 1'b1;
                    dec.muldiv    = 1'b1;
                    dec.muldiv_op = funct3;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            OP_IALU: begin
                dec.regwrite   = 1'b1;
                dec.alusrc     = 1'b1;
                dec.alucontrol = alu_f3;
            end
            OP_LOAD: begin
                dec.regwrite  = 1'b1;
                dec.alusrc    = 1'b1;
                dec.resultsrc = 2'b01;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                immsrc_d     = 3'b001;
            end
            OP_BR: begin
                dec.branch     = 1'b1;
                dec.alucontrol = ALU_SUB;
                immsrc_d       = 3'b010;
            end
            OP_JAL: begin
                dec.regwrite  = 1'b1;
                dec.jump      = 1'b1;
                dec.resultsrc = 2'b10;
                immsrc_d      = 3'b011;
            end
            OP_JALR: begin
                dec.regwrite  = 1'b1;
                dec.jump      = 1'b1;
                dec.alusrc    = 1'b1;
                dec.resultsrc = 2'b10;
            end
            OP_LUI: begin
                dec.regwrite   = 1'b1;
                dec.alusrc     = 1'b1;
                dec.alucontrol = ALU_PASSB;
                immsrc_d       = 3'b100;
            end
            OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                immsrc_d     = 3'b100;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Illegal encodings enter E as a bubble.
    assign dec_e = illegal_d ? ectrl_t'('0) : dec;
    assign div_e = e_q.muldiv & e_q.muldiv_op[2];

    // Divide sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
        end
    end

    // Divide sequencer next state. The first cycle of a divide in E is the IDLE cycle, so busy is raised there.
    // The cycle in which count reaches DIV_CYCLES-1 is the final, non-stalling cycle.
    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        div_busy = 1'b0;
        div_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_e) begin
                    if (DIV_CYCLES <= 1) begin
                        div_done = 1'b1;
                    end else begin
                        div_busy = 1'b1;
                        count_n  = CNT_W'(1);
                        state_n  = (count_n == LAST_CNT) ? S_LAST : S_RUN;
                    end
                end
            end
            S_RUN: begin
                div_busy = 1'b1;
                count_n  = count_q + CNT_W'(1);
                if (count_n == LAST_CNT) begin
                    state_n = S_LAST;
                end
            end
            S_LAST: begin
                div_done = 1'b1;
                count_n  = '0;
                state_n  = S_IDLE;
            end
            default: begin
                count_n = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    assign div_state = state_q;

    // Pipeline registers. Priority is reset, then divide hold, then flush, then advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q         <= '0;
            regwrite_m  <= 1'b0;
            memwrite_m  <= 1'b0;
            resultsrc_m <= 2'b00;
            regwrite_w  <= 1'b0;
            resultsrc_w <= 2'b00;
        end else begin
            regwrite_w  <= regwrite_m;
            resultsrc_w <= resultsrc_m;
            if (div_busy) begin
                regwrite_m  <= 1'b0;
                memwrite_m  <= 1'b0;
                resultsrc_m <= 2'b00;
            end else begin
                regwrite_m  <= e_q.regwrite;
                memwrite_m  <= e_q.memwrite;
                resultsrc_m <= e_q.resultsrc;
                e_q         <= flush_e ? ectrl_t'('0) : dec_e;
            end
        end
    end

    assign regwrite_e   = e_q.regwrite;
    assign memwrite_e   = e_q.memwrite;
    assign jump_e       = e_q.jump;
    assign branch_e     = e_q.branch;
    assign alusrc_e     = e_q.alusrc;
    assign resultsrc_e  = e_q.resultsrc;
    assign alucontrol_e = e_q.alucontrol;
    assign muldiv_e     = e_q.muldiv;
    assign muldiv_op_e  = e_q.muldiv_op;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe. It runs a decode vector table, directed multi-cycle sequences,
// and random traffic checked against a cycle-level reference model.
module tb_ctrl_pipe;

    localparam int DIV_CYCLES = 34;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       j;
        logic       br;
        logic       as;
        logic [1:0] rs;
        logic [3:0] alu;
        logic       md;
        logic [2:0] mop;
    } bun_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] imm;
        logic       ill;
        logic       ill_nm;
        bun_t       e;
    } vec_t;

    localparam logic [3:0] ALU_TAB [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
    localparam logic [6:0] OPS [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                        7'b0010111, 7'b0110011};

    // clock / reset
    logic clk = 1'b0;
    logic reset, flush_e;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    always #5 clk = ~clk;

    logic [2:0] immsrc_d, muldiv_op_e;
    logic       illegal_d, regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, muldiv_e;
    logic [1:0] resultsrc_e, resultsrc_m, resultsrc_w, div_state;
    logic [3:0] alucontrol_e;
    logic       regwrite_m, memwrite_m, regwrite_w, div_busy, div_done;

    logic [2:0] nm_immsrc_d, nm_muldiv_op_e;
    logic       nm_illegal_d, nm_regwrite_e, nm_memwrite_e, nm_jump_e, nm_branch_e, nm_alusrc_e, nm_muldiv_e;
    logic [1:0] nm_resultsrc_e, nm_resultsrc_m, nm_resultsrc_w, nm_div_state;
    logic [3:0] nm_alucontrol_e;
    logic       nm_regwrite_m, nm_memwrite_m, nm_regwrite_w, nm_div_busy, nm_div_done;

    ctrl_pipe #(.ENABLE_M(1), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .flush_e(flush_e),
        .immsrc_d(immsrc_d), .illegal_d(illegal_d), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
        .jump_e(jump_e), .branch_e(branch_e), .alusrc_e(alusrc_e), .resultsrc_e(resultsrc_e),
        .alucontrol_e(alucontrol_e), .muldiv_e(muldiv_e), .muldiv_op_e(muldiv_op_e),
        .regwrite_m(regwrite_m), .memwrite_m(memwrite_m), .resultsrc_m(resultsrc_m),
        .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w), .div_busy(div_busy),
        .div_done(div_done), .div_state(div_state)
    );

    ctrl_pipe #(.ENABLE_M(0), .DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut_nm (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .flush_e(flush_e),
        .immsrc_d(nm_immsrc_d), .illegal_d(nm_illegal_d), .regwrite_e(nm_regwrite_e),
        .memwrite_e(nm_memwrite_e), .jump_e(nm_jump_e), .branch_e(nm_branch_e),
        .alusrc_e(nm_alusrc_e), .resultsrc_e(nm_resultsrc_e), .alucontrol_e(nm_alucontrol_e),
        .muldiv_e(nm_muldiv_e), .muldiv_op_e(nm_muldiv_op_e), .regwrite_m(nm_regwrite_m),
        .memwrite_m(nm_memwrite_m), .resultsrc_m(nm_resultsrc_m), .regwrite_w(nm_regwrite_w),
        .resultsrc_w(nm_resultsrc_w), .div_busy(nm_div_busy), .div_done(nm_div_done),
        .div_state(nm_div_state)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bun_t bun(input logic rw, mw, j, br, as, input logic [1:0] rs,
                                 input logic [3:0] alu, input logic md, input logic [2:0] mop);
        bun_t b;
        b = '{rw: rw, mw: mw, j: j, br: br, as: as, rs: rs, alu: alu, md: md, mop: mop};
        return b;
    endfunction

    function automatic bun_t act_e();
        return {regwrite_e, memwrite_e, jump_e, branch_e, alusrc_e, resultsrc_e,
                alucontrol_e, muldiv_e, muldiv_op_e};
    endfunction

    function automatic bun_t act_e_nm();
        return {nm_regwrite_e, nm_memwrite_e, nm_jump_e, nm_branch_e, nm_alusrc_e, nm_resultsrc_e,
                nm_alucontrol_e, nm_muldiv_e, nm_muldiv_op_e};
    endfunction

    function automatic logic [27:0] act_vec();
        return {immsrc_d, illegal_d, div_busy, div_done, act_e(), regwrite_m, memwrite_m,
                resultsrc_m, regwrite_w, resultsrc_w};
    endfunction

    // Reference decode written from the instruction-class rules.
    function automatic void ref_decode(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                       input bit en_m, output bun_t b, output logic [2:0] imm,
                                       output logic ill);
        logic [3:0] alu;
        alu = ALU_TAB[f3];
        if (f3 == 3'd0 && f7[5] && o[5]) alu = 4'h1;
        if (f3 == 3'd5 && f7[5]) alu = 4'h9;
        b = '0; imm = 3'd0; ill = 1'b0;
        case (o)
            7'b0110011:
                if (f7 == 7'h00 || f7 == 7'h20) b = bun(1, 0, 0, 0, 0, 2'd0, alu, 0, 3'd0);
                else if (en_m && f7 == 7'h01) b = bun(1, 0, 0, 0, 0, 2'd0, 4'h0, 1, f3);
                else ill = 1'b1;
            7'b0010011: b = bun(1, 0, 0, 0, 1, 2'd0, alu, 0, 3'd0);
            7'b0000011: b = bun(1, 0, 0, 0, 1, 2'd1, 4'h0, 0, 3'd0);
            7'b0100011: begin b = bun(0, 1, 0, 0, 1, 2'd0, 4'h0, 0, 3'd0); imm = 3'd1; end
            7'b1100011: begin b = bun(0, 0, 0, 1, 0, 2'd0, 4'h1, 0, 3'd0); imm = 3'd2; end
            7'b1101111: begin b = bun(1, 0, 1, 0, 0, 2'd2, 4'h0, 0, 3'd0); imm = 3'd3; end
            7'b1100111: b = bun(1, 0, 1, 0, 1, 2'd2, 4'h0, 0, 3'd0);
            7'b0110111: begin b = bun(1, 0, 0, 0, 1, 2'd0, 4'hA, 0, 3'd0); imm = 3'd4; end
            7'b0010111: begin b = bun(1, 0, 0, 0, 1, 2'd0, 4'h0, 0, 3'd0); imm = 3'd4; end
            default: ill = 1'b1;
        endcase
        if (ill) b = '0;
    endfunction

    // Reference pipeline: E bundle, M/W fields, and how long the current E content has been resident.
    bun_t       me;
    logic       m_rw, m_mw, w_rw;
    logic [1:0] m_rs, w_rs;
    int         age;

    function automatic logic model_div();
        return me.md && me.mop[2];
    endfunction

    function automatic logic model_busy();
        return model_div() && (age < DIV_CYCLES - 1);
    endfunction

    function automatic logic [27:0] exp_vec();
        bun_t b; logic [2:0] imm; logic ill; logic dn;
        ref_decode(op, funct3, funct7, 1'b1, b, imm, ill);
        dn = model_div() && (age == DIV_CYCLES - 1);
        return {imm, ill, model_busy(), dn, me, m_rw, m_mw, m_rs, w_rw, w_rs};
    endfunction

    task automatic model_clear();
        me = '0; m_rw = 0; m_mw = 0; m_rs = 0; w_rw = 0; w_rs = 0; age = 0;
    endtask

    task automatic model_step();
        bun_t b; logic [2:0] imm; logic ill;
        if (reset) begin
            model_clear();
        end else begin
            ref_decode(op, funct3, funct7, 1'b1, b, imm, ill);
            w_rw = m_rw; w_rs = m_rs;
            if (model_busy()) begin
                m_rw = 0; m_mw = 0; m_rs = 0; age++;
            end else begin
                m_rw = me.rw; m_mw = me.mw; m_rs = me.rs;
                me = flush_e ? bun_t'('0) : b;
                age = 0;
            end
        end
    endtask

    // driver tasks
    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic fl);
        op = o; funct3 = f3; funct7 = f7; flush_e = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(7'h7f, 3'd0, 7'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tab[$];

    task automatic add_vec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] imm, input logic ill, input logic ill_nm, input bun_t e);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.imm = imm; v.ill = ill; v.ill_nm = ill_nm; v.e = e;
        tab.push_back(v);
    endtask

    initial begin
        int busy_n, done_n, bad_e, bad_m, done_seen;
        bun_t e0;

        // decode vectors: op, f3, f7, immsrc, illegal (M on), illegal (M off), E bundle
        add_vec(7'b0110011, 3'd0, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h0,0,3'd0)); // add
        add_vec(7'b0110011, 3'd0, 7'h20, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h1,0,3'd0)); // sub
        add_vec(7'b0110011, 3'd1, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h7,0,3'd0)); // sll
        add_vec(7'b0110011, 3'd2, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h5,0,3'd0)); // slt
        add_vec(7'b0110011, 3'd3, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h6,0,3'd0)); // sltu
        add_vec(7'b0110011, 3'd4, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h4,0,3'd0)); // xor
        add_vec(7'b0110011, 3'd5, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h8,0,3'd0)); // srl
        add_vec(7'b0110011, 3'd5, 7'h20, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h9,0,3'd0)); // sra
        add_vec(7'b0110011, 3'd6, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h3,0,3'd0)); // or
        add_vec(7'b0110011, 3'd7, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,0,2'd0,4'h2,0,3'd0)); // and
        add_vec(7'b0010011, 3'd0, 7'h20, 3'd0, 0, 0, bun(1,0,0,0,1,2'd0,4'h0,0,3'd0)); // addi
        add_vec(7'b0010011, 3'd5, 7'h20, 3'd0, 0, 0, bun(1,0,0,0,1,2'd0,4'h9,0,3'd0)); // srai
        add_vec(7'b0010011, 3'd1, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,1,2'd0,4'h7,0,3'd0)); // slli
        add_vec(7'b0000011, 3'd2, 7'h00, 3'd0, 0, 0, bun(1,0,0,0,1,2'd1,4'h0,0,3'd0)); // lw
        add_vec(7'b0100011, 3'd2, 7'h00, 3'd1, 0, 0, bun(0,1,0,0,1,2'd0,4'h0,0,3'd0)); // sw
        add_vec(7'b1100011, 3'd0, 7'h00, 3'd2, 0, 0, bun(0,0,0,1,0,2'd0,4'h1,0,3'd0)); // beq
        add_vec(7'b1101111, 3'd0, 7'h00, 3'd3, 0, 0, bun(1,0,1,0,0,2'd2,4'h0,0,3'd0)); // jal
        add_vec(7'b1100111, 3'd0, 7'h00, 3'd0, 0, 0, bun(1,0,1,0,1,2'd2,4'h0,0,3'd0)); // jalr
        add_vec(7'b0110111, 3'd0, 7'h00, 3'd4, 0, 0, bun(1,0,0,0,1,2'd0,4'hA,0,3'd0)); // lui
        add_vec(7'b0010111, 3'd0, 7'h00, 3'd4, 0, 0, bun(1,0,0,0,1,2'd0,4'h0,0,3'd0)); // auipc
        add_vec(7'b0110011, 3'd0, 7'h01, 3'd0, 0, 1, bun(1,0,0,0,0,2'd0,4'h0,1,3'd0)); // mul
        add_vec(7'b0110011, 3'd3, 7'h01, 3'd0, 0, 1, bun(1,0,0,0,0,2'd0,4'h0,1,3'd3)); // mulhu
        add_vec(7'b0110011, 3'd0, 7'h40, 3'd0, 1, 1, bun(0,0,0,0,0,2'd0,4'h0,0,3'd0)); // bad f7
        add_vec(7'b1111111, 3'd0, 7'h00, 3'd0, 1, 1, bun(0,0,0,0,0,2'd0,4'h0,0,3'd0)); // bad op

        // reset state
        do_reset();
        check("reset_regs", act_vec() & 28'h0FF_FFFF, 28'd0);
        check("reset_state", div_state, 2'd0);

        // decode table
        foreach (tab[i]) begin
            drive(tab[i].op, tab[i].f3, tab[i].f7, 1'b0);
            #1;
            check($sformatf("imm[%0d]", i), immsrc_d, tab[i].imm);
            check($sformatf("ill[%0d]", i), illegal_d, tab[i].ill);
            check($sformatf("ill_nm[%0d]", i), nm_illegal_d, tab[i].ill_nm);
            step();
            check($sformatf("e[%0d]", i), act_e(), tab[i].e);
            check($sformatf("e_nm[%0d]", i), act_e_nm(), tab[i].ill_nm ? bun_t'('0) : tab[i].e);
        end

        // add then sub, add reaches W three edges after D
        do_reset();
        drive(7'b0110011, 3'd0, 7'h00, 1'b0); step();
        check("add_alu_e", alucontrol_e, 4'h0);
        drive(7'b0110011, 3'd0, 7'h20, 1'b0); step();
        check("sub_alu_e", alucontrol_e, 4'h1);
        check("add_rw_m", regwrite_m, 1'b1);
        drive(7'h7f, 3'd0, 7'h00, 1'b0); step();
        check("add_rw_w", {regwrite_w, resultsrc_w}, 3'b100);

        // beq, then flush loads a bubble that never writes downstream
        do_reset();
        drive(7'b1100011, 3'd0, 7'h00, 1'b0); step();
        check("beq_e", branch_e, 1'b1);
        drive(7'b0110011, 3'd0, 7'h00, 1'b1); step();
        check("flush_e_zero", act_e(), bun_t'('0));
        drive(7'h7f, 3'd0, 7'h00, 1'b0); step();
        check("flush_m", {regwrite_m, memwrite_m}, 2'b00);
        step();
        check("flush_w", regwrite_w, 1'b0);

        // divide: busy DIV_CYCLES-1 cycles then a single done; E frozen, flush ignored, M bubbled
        do_reset();
        drive(7'b0110011, 3'd4, 7'h01, 1'b0); step();
        e0 = act_e();
        check("div_e", e0, bun(1,0,0,0,0,2'd0,4'h0,1,3'd4));
        drive(7'h7f, 3'd0, 7'h00, 1'b1);
        busy_n = 0; done_n = 0; bad_e = 0; bad_m = 0; done_seen = 0;
        for (int c = 0; c < 80; c++) begin
            if (div_busy) begin
                busy_n++;
                if (act_e() !== e0) bad_e++;
                if (regwrite_m !== 1'b0) bad_m++;
            end
            if (div_done) begin
                done_n++;
                done_seen = 1;
            end
            if (done_seen != 0) break;
            step();
        end
        check("div_timeout", done_seen, 1);
        check("div_busy_cycles", busy_n, DIV_CYCLES - 1);
        check("div_done_cycles", done_n, 1);
        check("div_e_held", bad_e, 0);
        check("div_m_bubble", bad_m, 0);
        step();
        check("div_to_m", regwrite_m, 1'b1);
        check("div_after_e", act_e(), bun_t'('0));
        check("div_after_busy", {div_busy, div_done}, 2'b00);

        // reset during a divide
        do_reset();
        drive(7'b0110011, 3'd5, 7'h01, 1'b0); step();
        drive(7'h7f, 3'd0, 7'h00, 1'b0);
        repeat (9) step();
        check("mid_div_busy", div_busy, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        check("rst_div_regs", act_vec() & 28'h0FF_FFFF, 28'd0);
        check("rst_div_state", div_state, 2'd0);
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (div_done || div_busy) done_n++;
            step();
        end
        check("rst_div_quiet", done_n, 0);

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int idx;
            @(posedge clk);
            model_step();
            #1;
            idx = $urandom_range(0, 10);
            op = (idx == 10) ? 7'($urandom) : OPS[idx];
            funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            flush_e = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 79) == 0);
            #1;
            check($sformatf("rand[%0d]", c), act_vec(), exp_vec());
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
